// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared types and helpers for the DMA channel priority arbiter.
//   NUM_CH      number of arbitrated channels (fixed at 4)
//   CH_W        width of a channel index
//   ch_t        channel index type
//   arb_state_t arbiter FSM state encoding
//   chOneHot    channel index to one-hot channel vector
package dma_arb_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W = 2;
    typedef logic [CH_W-1:0] ch_t;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;
    function automatic logic [NUM_CH-1:0] chOneHot(input ch_t ch);
        return NUM_CH'(1) << ch;
    endfunction
endpackage

// File: rtl/dma_prio_encoder.sv
// dma_prio_encoder: combinational priority pick among four channel requests.
//   reqVec   in  effective per-channel requests
//   prioPtr  in  channel currently holding highest priority; order wraps upward
//   winner   out index of the highest-priority active request (0 when none)
//   anyValid out at least one request is active
module dma_prio_encoder
    import dma_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] reqVec,
    input  ch_t               prioPtr,
    output ch_t               winner,
    output logic              anyValid
);
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (reqVec[prioPtr + ch_t'(i)]) winner = prioPtr + ch_t'(i);
        end
    end
    assign anyValid = |reqVec;
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 8237-style DMA channel arbiter with hold handshake.
//   CLK, RESET_N     clock, asynchronous active-low reset
//   DREQ             raw channel requests, polarity set by DREQ_ACT_LOW
//   DACK_ACT_HIGH    acknowledge polarity
//   ROTATE           rotating (1) or fixed (0) priority
//   CTRL_DISABLE     blocks new arbitration
//   MASK, SW_REQ     per-channel mask and software requests
//   HLDA             hold acknowledge from the CPU
//   CYCLE_DONE,EOP_N end-of-transfer pulse and end-of-process flag
//   HRQ              hold request to the CPU
//   VALID_DREQ, DACK one-hot granted channel and polarity-adjusted acknowledge
//   GRANT_CH         latched granted channel index
//   TC_SET           one-cycle terminal-count pulse per channel
//   BUSY             FSM not idle
// Build option: define DMA_ROTATE_PRIO_EN to honour ROTATE; otherwise fixed
// priority always applies and no pointer register exists.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              DREQ_ACT_LOW,
    input  logic              DACK_ACT_HIGH,
    input  logic              ROTATE,
    input  logic              CTRL_DISABLE,
    input  logic [NUM_CH-1:0] MASK,
    input  logic [NUM_CH-1:0] SW_REQ,
    input  logic              HLDA,
    input  logic              CYCLE_DONE,
    input  logic              EOP_N,
    output logic              HRQ,
    output logic [NUM_CH-1:0] VALID_DREQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [CH_W-1:0]   GRANT_CH,
    output logic [NUM_CH-1:0] TC_SET,
    output logic              BUSY
);
    import dma_arb_pkg::*;

    arb_state_t        state;
    arb_state_t        nextState;
    logic [NUM_CH-1:0] dreqReg;
    logic [NUM_CH-1:0] effReq;
    logic [NUM_CH-1:0] tcSet;
    ch_t               grantCh;
    ch_t               winner;
    ch_t               prioPtr;
    logic              anyReq;
    logic              grantDone;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) dreqReg <= '0;
        else dreqReg <= DREQ ^ {NUM_CH{DREQ_ACT_LOW}};
    end

    assign effReq = (dreqReg | SW_REQ) & ~MASK & {NUM_CH{~CTRL_DISABLE}};

    // A normal transfer end; an HLDA drop takes precedence and aborts instead.
    assign grantDone = (state == GRANT) && HLDA && CYCLE_DONE;

`ifdef DMA_ROTATE_PRIO_EN
    ch_t rotPtr;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rotPtr <= '0;
        else if (grantDone && ROTATE) rotPtr <= grantCh + 1'b1;
    end
    assign prioPtr = ROTATE ? rotPtr : '0;
`else
    logic unusedRotate;
    assign unusedRotate = ROTATE;
    assign prioPtr = '0;
`endif

    dma_prio_encoder u_enc (
        .reqVec  (effReq),
        .prioPtr (prioPtr),
        .winner  (winner),
        .anyValid(anyReq)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = anyReq ? REQ : IDLE;
            REQ:     nextState = HLDA ? GRANT : (effReq[grantCh] ? REQ : IDLE);
            GRANT:   nextState = !HLDA ? IDLE : (CYCLE_DONE ? RELEASE : GRANT);
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            grantCh <= '0;
            tcSet   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && anyReq) grantCh <= winner;
            tcSet <= (grantDone && !EOP_N) ? chOneHot(grantCh) : '0;
        end
    end

    assign HRQ        = (state == REQ) || (state == GRANT);
    assign VALID_DREQ = (state == GRANT) ? chOneHot(grantCh) : '0;
    assign DACK       = VALID_DREQ ^ {NUM_CH{~DACK_ACT_HIGH}};
    assign GRANT_CH   = grantCh;
    assign TC_SET     = tcSet;
    assign BUSY       = state != IDLE;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: randomized scoreboard bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;
`ifdef DMA_ROTATE_PRIO_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct {
        int         ch;
        logic [3:0] oh;
        logic [3:0] dack;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       DREQ_ACT_LOW;
    logic       DACK_ACT_HIGH;
    logic       ROTATE;
    logic       CTRL_DISABLE;
    logic [3:0] MASK;
    logic [3:0] SW_REQ;
    logic       HLDA;
    logic       CYCLE_DONE;
    logic       EOP_N;
    logic       HRQ;
    logic [3:0] VALID_DREQ;
    logic [3:0] DACK;
    logic [1:0] GRANT_CH;
    logic [3:0] TC_SET;
    logic       BUSY;

    exp_t       grantQ[$];
    logic [3:0] tcQ[$];
    exp_t       me;
    logic [3:0] mt;
    logic [3:0] prevValid = '0;
    int         nCheck = 0;
    int         nPass = 0;
    int         modelPtr = 0;

    dma_priority_arbiter dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .DREQ_ACT_LOW (DREQ_ACT_LOW),
        .DACK_ACT_HIGH(DACK_ACT_HIGH),
        .ROTATE       (ROTATE),
        .CTRL_DISABLE (CTRL_DISABLE),
        .MASK         (MASK),
        .SW_REQ       (SW_REQ),
        .HLDA         (HLDA),
        .CYCLE_DONE   (CYCLE_DONE),
        .EOP_N        (EOP_N),
        .HRQ          (HRQ),
        .VALID_DREQ   (VALID_DREQ),
        .DACK         (DACK),
        .GRANT_CH     (GRANT_CH),
        .TC_SET       (TC_SET),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCheck++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every new grant and every TC pulse is matched against the scoreboard.
    always @(negedge CLK) begin
        if (VALID_DREQ != 4'b0 && prevValid == 4'b0) begin
            if (grantQ.size() == 0) begin
                nCheck++;
                $display("FAIL unexpected grant: VALID_DREQ=%b with nothing queued", VALID_DREQ);
            end else begin
                me = grantQ.pop_front();
                chk("GRANT_CH", 32'(GRANT_CH), me.ch);
                chk("VALID_DREQ", 32'(VALID_DREQ), 32'(me.oh));
                chk("DACK", 32'(DACK), 32'(me.dack));
            end
        end
        if (TC_SET != 4'b0) begin
            if (tcQ.size() == 0) begin
                nCheck++;
                $display("FAIL unexpected TC_SET: got %b with nothing queued", TC_SET);
            end else begin
                mt = tcQ.pop_front();
                chk("TC_SET", 32'(TC_SET), 32'(mt));
            end
        end
        prevValid = VALID_DREQ;
    end

    // mode: 0 full transfer, 1 request withdrawn before HLDA, 2 HLDA dropped mid-grant
    task automatic episode(input logic [3:0] raw, input bit pol, input logic [3:0] sw,
                           input logic [3:0] mask, input bit dis, input bit ah, input bit rot,
                           input int mode, input int hDelay, input int gHold,
                           input bit gMask, input bit eop);
        logic [3:0] eff;
        int ptr;
        int ch;
        exp_t e;
        DREQ = raw; DREQ_ACT_LOW = pol; DACK_ACT_HIGH = ah; ROTATE = rot;
        SW_REQ = 4'b0; MASK = 4'hF; CTRL_DISABLE = 1'b0;
        HLDA = 1'b0; CYCLE_DONE = 1'b0; EOP_N = 1'b1;
        tick();
        SW_REQ = sw; MASK = mask; CTRL_DISABLE = dis;
        eff = ((raw ^ {4{pol}}) | sw) & ~mask & {4{~dis}};
        if (eff == 4'b0) begin
            repeat (3) tick();
            chk("no request HRQ", 32'(HRQ), 0);
            chk("no request BUSY", 32'(BUSY), 0);
            return;
        end
        ptr = (ROT_EN && rot) ? modelPtr : 0;
        ch = -1;
        for (int k = 0; k < 4; k++) if (ch < 0 && eff[(ptr + k) % 4]) ch = (ptr + k) % 4;
        tick();
        chk("HRQ rise", 32'(HRQ), 1);
        repeat (hDelay) tick();
        chk("HRQ wait", 32'({HRQ, VALID_DREQ}), 32'h10);
        if (mode == 1) begin
            MASK = 4'hF;
            tick();
            chk("withdrawn HRQ/BUSY", 32'({HRQ, BUSY}), 0);
            return;
        end
        e.ch = ch;
        e.oh = 4'(1 << ch);
        e.dack = ah ? e.oh : ~e.oh;
        grantQ.push_back(e);
        HLDA = 1'b1;
        tick();
        if (gMask) begin
            MASK = 4'hF;
            CTRL_DISABLE = 1'b1;
        end
        repeat (gHold) tick();
        chk("grant held", 32'(VALID_DREQ), 32'(e.oh));
        if (mode == 2) begin
            HLDA = 1'b0;
            MASK = 4'hF;
            tick();
            CTRL_DISABLE = 1'b0;
            chk("abort VALID_DREQ", 32'(VALID_DREQ), 0);
            chk("abort DACK", 32'(DACK), ah ? 32'h0 : 32'hF);
            chk("abort BUSY", 32'(BUSY), 0);
            return;
        end
        CYCLE_DONE = 1'b1;
        EOP_N = eop;
        if (!eop) tcQ.push_back(e.oh);
        tick();
        CYCLE_DONE = 1'b0; EOP_N = 1'b1; HLDA = 1'b0; MASK = 4'hF; CTRL_DISABLE = 1'b0;
        chk("release HRQ/VALID/BUSY", 32'({HRQ, VALID_DREQ, BUSY}), 32'h01);
        if (ROT_EN && rot) modelPtr = (ch + 1) % 4;
        tick();
        chk("back to idle", 32'(BUSY), 0);
    endtask

    task automatic checkResetOutputs(input string nm);
        chk({nm, " HRQ"}, 32'(HRQ), 0);
        chk({nm, " VALID_DREQ"}, 32'(VALID_DREQ), 0);
        chk({nm, " GRANT_CH"}, 32'(GRANT_CH), 0);
        chk({nm, " TC_SET"}, 32'(TC_SET), 0);
        chk({nm, " BUSY"}, 32'(BUSY), 0);
        chk({nm, " DACK"}, 32'(DACK), 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        DREQ = 4'b0; DREQ_ACT_LOW = 1'b0; DACK_ACT_HIGH = 1'b1; ROTATE = 1'b0;
        CTRL_DISABLE = 1'b0; MASK = 4'hF; SW_REQ = 4'b0;
        HLDA = 1'b0; CYCLE_DONE = 1'b0; EOP_N = 1'b1;
        #1;
        checkResetOutputs("reset");
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        // fixed priority: 1010 -> channel 1, then only channel 3 left
        episode(4'b1010, 0, 4'b0, 4'b0, 0, 1, 0, 0, 2, 1, 0, 1);
        episode(4'b1000, 0, 4'b0, 4'b0, 0, 1, 0, 0, 2, 0, 0, 1);
        // rotating priority with all requests held
        repeat (5) episode(4'b1111, 0, 4'b0, 4'b0, 0, 1, 1, 0, 1, 1, 0, 1);
        // masked hardware request, then software request on channel 2
        episode(4'b0001, 0, 4'b0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 1);
        episode(4'b0001, 0, 4'b0100, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 1);
        // active-low request and acknowledge
        episode(4'b1110, 1, 4'b0, 4'b0, 0, 0, 0, 0, 1, 1, 0, 1);
        // controller disabled blocks everything
        episode(4'b1111, 0, 4'b1111, 4'b0, 1, 1, 0, 0, 0, 0, 0, 1);
        // terminal count on channel 3, mask/disable during grant
        episode(4'b1000, 0, 4'b0, 4'b0, 0, 1, 0, 0, 0, 2, 1, 0);
        // withdrawn request and HLDA abort
        episode(4'b0100, 0, 4'b0, 4'b0, 0, 1, 0, 1, 1, 0, 0, 1);
        episode(4'b0010, 0, 4'b0, 4'b0, 0, 0, 0, 2, 0, 1, 0, 0);

        // asynchronous reset in the middle of a grant
        DREQ = 4'b0100; DREQ_ACT_LOW = 1'b0; DACK_ACT_HIGH = 1'b1; SW_REQ = 4'b0;
        MASK = 4'hF; CTRL_DISABLE = 1'b0;
        tick();
        MASK = 4'b0;
        me.ch = 2; me.oh = 4'b0100; me.dack = 4'b0100;
        grantQ.push_back(me);
        tick();
        HLDA = 1'b1;
        tick();
        #5;
        RESET_N = 1'b0;
        #1;
        checkResetOutputs("async reset");
        HLDA = 1'b0; MASK = 4'hF; CYCLE_DONE = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        modelPtr = 0;
        tick();

        for (int n = 0; n < 60; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            episode(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
                    4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (r < 7) ? 0 : ((r == 7) ? 1 : 2),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        chk("grant queue drained", grantQ.size(), 0);
        chk("tc queue drained", tcQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end
endmodule
